// File: rtl/y86_alu_exec_if.sv
// ---------------------------------------------------------------------------
// y86_alu_exec_if
//   Operand/result stream bundle for the Y86-64 OPq execute unit.
//
//   Signals
//     in_valid   operand beat valid               (producer -> unit)
//     in_ready   unit can accept a beat            (unit -> producer)
//     in_ifun    0 addq, 1 subq, 2 andq, 3 xorq    (producer -> unit)
//     in_a       valA operand, signed              (producer -> unit)
//     in_b       valB operand, signed              (producer -> unit)
//     in_setcc   beat updates the CC register      (producer -> unit)
//     out_valid  result beat valid                 (unit -> consumer)
//     out_ready  consumer accepts result           (consumer -> unit)
//     out_vale   result valE = B op A              (unit -> consumer)
//     out_cc     {ZF,SF,OF} of this result         (unit -> consumer)
//     out_err    illegal ifun (or trapped overflow) on this beat
//     cc_q       architectural CC register {ZF,SF,OF}
//
//   Modports
//     master  the surrounding pipeline (drives operands, consumes results)
//     slave   the execute unit itself
// ---------------------------------------------------------------------------
interface y86_alu_exec_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_ifun;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_setcc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vale;
    logic [2:0]       out_cc;
    logic             out_err;
    logic [2:0]       cc_q;

    modport master (
        output in_valid, in_ifun, in_a, in_b, in_setcc, out_ready,
        input  in_ready, out_valid, out_vale, out_cc, out_err, cc_q
    );

    modport slave (
        input  in_valid, in_ifun, in_a, in_b, in_setcc, out_ready,
        output in_ready, out_valid, out_vale, out_cc, out_err, cc_q
    );
endinterface

// File: rtl/y86_alu_exec.sv
// ---------------------------------------------------------------------------
// y86_alu_exec
//   Registered Y86-64 OPq execute unit. Accepts operand pairs over a
//   valid/ready handshake, computes valE = B op A with fresh ZF/SF/OF, and
//   holds the architectural condition-code register. The output side is a
//   two-entry elastic buffer (main slot + skid slot) so one op per cycle is
//   sustained even under backpressure, while in_ready stays a pure register
//   output with no combinational dependence on out_ready.
//
//   Parameters
//     WIDTH   operand/result width; OF and SF use bit WIDTH-1
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous active-high reset
//     bus     y86_alu_exec_if.slave (operand stream in, result stream out,
//             CC register out)
//
//   Configuration macro
//     Y86_ALU_OVF_TRAP_EN  when defined, a legal addq/subq that overflows
//                          also raises out_err on that beat (cc_q is still
//                          written when in_setcc=1). When undefined,
//                          out_err flags illegal ifun only.
// ---------------------------------------------------------------------------
module y86_alu_exec #(
    parameter int WIDTH = 64
) (
    input logic           clk,
    input logic           rst,
    y86_alu_exec_if.slave bus
);

    localparam logic [3:0] IFUN_ADD = 4'd0;
    localparam logic [3:0] IFUN_SUB = 4'd1;
    localparam logic [3:0] IFUN_AND = 4'd2;
    localparam logic [3:0] IFUN_XOR = 4'd3;

    // Occupancy of the output buffer. ONE means only the main slot is
    // full; TWO means the skid slot holds a beat behind it.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } bufState_t;

    bufState_t        r_state;
    bufState_t        w_nextState;

    logic [WIDTH-1:0] r_mainVale;
    logic [2:0]       r_mainCc;
    logic             r_mainErr;
    logic [WIDTH-1:0] r_skidVale;
    logic [2:0]       r_skidCc;
    logic             r_skidErr;
    logic [2:0]       r_cc;

    logic             w_accept;
    logic             w_drain;
    logic             w_loadMainFromIn;
    logic             w_loadMainFromSkid;
    logic             w_loadSkid;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_of;
    logic             w_illegal;
    logic [2:0]       w_flags;
    logic             w_err;

    // in_ready only depends on whether the skid slot is free, so the
    // producer never sees a combinational path from out_ready.
    assign bus.in_ready  = (r_state != BUF_TWO);
    assign bus.out_valid = (r_state != BUF_EMPTY);
    assign bus.out_vale  = r_mainVale;
    assign bus.out_cc    = r_mainCc;
    assign bus.out_err   = r_mainErr;
    assign bus.cc_q      = r_cc;

    assign w_accept = bus.in_valid && (r_state != BUF_TWO);
    assign w_drain  = (r_state != BUF_EMPTY) && bus.out_ready;

    assign w_sum  = bus.in_b + bus.in_a;
    assign w_diff = bus.in_b - bus.in_a;

    // Operation select and flag generation for the incoming beat. Overflow
    // is detected from operand/result sign bits: for add, both operands
    // agree in sign but the result does not; for sub (b - a), the operands
    // disagree and the result sign moved away from b.
    always_comb begin
        w_result  = '0;
        w_of      = 1'b0;
        w_illegal = 1'b0;
        case (bus.in_ifun)
            IFUN_ADD: begin
                w_result = w_sum;
                w_of     = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            IFUN_SUB: begin
                w_result = w_diff;
                w_of     = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != bus.in_b[WIDTH-1]);
            end
            IFUN_AND: w_result = bus.in_b & bus.in_a;
            IFUN_XOR: w_result = bus.in_b ^ bus.in_a;
            default:  w_illegal = 1'b1;
        endcase

        w_flags = w_illegal ? 3'b000
                            : {(w_result == '0), w_result[WIDTH-1], w_of};
`ifdef Y86_ALU_OVF_TRAP_EN
        w_err = w_illegal || w_of;
`else
        w_err = w_illegal;
`endif
    end

    // Buffer control. A beat lands in the main slot whenever the main slot
    // is free at the edge (empty, or draining this cycle); otherwise it
    // parks in the skid slot. When the main slot drains while the skid is
    // full, the skid beat moves forward. Accept and drain with a full skid
    // cannot coincide because in_ready is low in that state.
    always_comb begin
        w_nextState        = r_state;
        w_loadMainFromIn   = 1'b0;
        w_loadMainFromSkid = 1'b0;
        w_loadSkid         = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_loadMainFromIn = 1'b1;
                    w_nextState      = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (w_accept && w_drain) begin
                    w_loadMainFromIn = 1'b1;
                end else if (w_accept) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = BUF_TWO;
                end else if (w_drain) begin
                    w_nextState = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_drain) begin
                    w_loadMainFromSkid = 1'b1;
                    w_nextState        = BUF_ONE;
                end
            end
            default: w_nextState = BUF_EMPTY;
        endcase
    end

    // Buffer occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Result payload registers. The main slot keeps its value when idle,
    // which holds out_* stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mainVale <= '0;
            r_mainCc   <= 3'b000;
            r_mainErr  <= 1'b0;
            r_skidVale <= '0;
            r_skidCc   <= 3'b000;
            r_skidErr  <= 1'b0;
        end else begin
            if (w_loadMainFromIn) begin
                r_mainVale <= w_illegal ? '0 : w_result;
                r_mainCc   <= w_flags;
                r_mainErr  <= w_err;
            end else if (w_loadMainFromSkid) begin
                r_mainVale <= r_skidVale;
                r_mainCc   <= r_skidCc;
                r_mainErr  <= r_skidErr;
            end
            if (w_loadSkid) begin
                r_skidVale <= w_illegal ? '0 : w_result;
                r_skidCc   <= w_flags;
                r_skidErr  <= w_err;
            end
        end
    end

    // Architectural CC register: written at the accept edge by legal ops
    // that request it, so among back-to-back setcc ops the last one wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= 3'b100;
        end else if (w_accept && !w_illegal && bus.in_setcc) begin
            r_cc <= w_flags;
        end
    end

endmodule
